// File: rtl/note_judge_pkg.sv
// Shared definitions for the note judge: FSM encoding, scoring constants,
// combo bonus threshold and song length.
package note_judge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } judge_state_e;

  localparam int BEAT_W_DEF      = 7;
  localparam int NOTE_W_DEF      = 6;
  localparam int KEY_W_DEF       = 4;
  localparam int SCORE_W_DEF     = 14;
  localparam int LAST_BEAT_DEF   = 96;
  localparam int PERFECT_PTS_DEF = 3;
  localparam int GOOD_PTS_DEF    = 1;

  // Pre-hit combo at which a perfect hit earns double points (bonus build only)
  localparam int BONUS_COMBO     = 10;

endpackage

// File: rtl/judge_score_acc.sv
// Score / combo / max-combo accumulator for the note judge.
// Optional build macro NOTE_JUDGE_COMBO_BONUS_EN: a perfect hit whose pre-hit
// combo is at least BONUS_COMBO scores 2*PERFECT_PTS instead of PERFECT_PTS.
module judge_score_acc
  import note_judge_pkg::*;
#(
  parameter int NOTE_W      = NOTE_W_DEF,
  parameter int SCORE_W     = SCORE_W_DEF,
  parameter int PERFECT_PTS = PERFECT_PTS_DEF,
  parameter int GOOD_PTS    = GOOD_PTS_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               hit,
  input  logic               perfect,
  input  logic               miss,
  output logic [SCORE_W-1:0] score,
  output logic [NOTE_W-1:0]  combo,
  output logic [NOTE_W-1:0]  max_combo
);

  logic [SCORE_W-1:0] score_q, score_d;
  logic [NOTE_W-1:0]  combo_q, combo_d;
  logic [NOTE_W-1:0]  max_combo_q, max_combo_d;
  logic [NOTE_W-1:0]  base_combo;
  logic [SCORE_W-1:0] pts;
  logic [SCORE_W:0]   sum;

  // Next counter values; a miss in the same cycle as a hit is applied first
  always_comb begin
    score_d     = score_q;
    combo_d     = combo_q;
    max_combo_d = max_combo_q;
    base_combo  = miss ? '0 : combo_q;
    pts         = perfect ? SCORE_W'(PERFECT_PTS) : SCORE_W'(GOOD_PTS);
`ifdef NOTE_JUDGE_COMBO_BONUS_EN
    if (perfect && (base_combo >= NOTE_W'(BONUS_COMBO))) begin
      pts = SCORE_W'(2 * PERFECT_PTS);
    end
`endif
    sum = {1'b0, score_q} + {1'b0, pts};
    if (clear) begin
      score_d     = '0;
      combo_d     = '0;
      max_combo_d = '0;
    end else begin
      if (hit) begin
        combo_d = (base_combo == '1) ? base_combo : base_combo + NOTE_W'(1);
        score_d = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
      end else if (miss) begin
        combo_d = '0;
      end
      if (combo_d > max_combo_q) begin
        max_combo_d = combo_d;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_q     <= '0;
      combo_q     <= '0;
      max_combo_q <= '0;
    end else begin
      score_q     <= score_d;
      combo_q     <= combo_d;
      max_combo_q <= max_combo_d;
    end
  end

  assign score     = score_q;
  assign combo     = combo_q;
  assign max_combo = max_combo_q;

endmodule

// File: rtl/note_judge.sv
// Note judge: detects new notes, grades key presses as perfect/good/miss and
// runs the IDLE/PLAY/DONE game FSM. Counters live in judge_score_acc.
// Optional build macro NOTE_JUDGE_COMBO_BONUS_EN enables the combo bonus.
module note_judge
  import note_judge_pkg::*;
#(
  parameter int BEAT_W      = BEAT_W_DEF,
  parameter int NOTE_W      = NOTE_W_DEF,
  parameter int KEY_W       = KEY_W_DEF,
  parameter int SCORE_W     = SCORE_W_DEF,
  parameter int LAST_BEAT   = LAST_BEAT_DEF,
  parameter int PERFECT_PTS = PERFECT_PTS_DEF,
  parameter int GOOD_PTS    = GOOD_PTS_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [BEAT_W-1:0]  beat_cnt,
  input  logic [NOTE_W-1:0]  note_idx,
  input  logic [KEY_W-1:0]   note_key,
  input  logic               key_valid,
  input  logic [KEY_W-1:0]   key_code,
  output logic               hit_pulse,
  output logic               hit_perfect,
  output logic               miss_pulse,
  output logic [SCORE_W-1:0] score,
  output logic [NOTE_W-1:0]  combo,
  output logic [NOTE_W-1:0]  max_combo,
  output logic               playing,
  output logic               done
);

  localparam logic [BEAT_W-1:0] LAST = BEAT_W'(LAST_BEAT);

  judge_state_e      state_q, state_d;
  logic              pending_q, pending_d;
  logic              first_beat_q, first_beat_d;
  logic [KEY_W-1:0]  exp_key_q, exp_key_d;
  logic [NOTE_W-1:0] prev_idx_q, prev_idx_d;
  logic [BEAT_W-1:0] prev_beat_q, prev_beat_d;
  logic              hit_q, hit_d;
  logic              perfect_q, perfect_d;
  logic              miss_q, miss_d;
  logic              clear;
  logic              new_note;
  logic              cur_pending;
  logic              cur_first;
  logic [KEY_W-1:0]  cur_key;

  // FSM next state, note detection and grading of the pending note
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    first_beat_d = first_beat_q;
    exp_key_d    = exp_key_q;
    prev_idx_d   = note_idx;
    prev_beat_d  = beat_cnt;
    hit_d        = 1'b0;
    perfect_d    = 1'b0;
    miss_d       = 1'b0;
    clear        = 1'b0;
    new_note     = 1'b0;
    cur_pending  = pending_q;
    cur_first    = first_beat_q;
    cur_key      = exp_key_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_PLAY;
          clear        = 1'b1;
          pending_d    = 1'b0;
          first_beat_d = 1'b0;
        end
      end
      ST_PLAY: begin
        new_note = (note_idx != prev_idx_q) && (note_idx != '0);
        if (new_note) begin
          miss_d      = pending_q;
          cur_pending = 1'b1;
          cur_first   = 1'b1;
          cur_key     = note_key;
        end else if (beat_cnt != prev_beat_q) begin
          cur_first = 1'b0;
        end
        pending_d    = cur_pending;
        first_beat_d = cur_first;
        exp_key_d    = cur_key;
        if (key_valid && cur_pending) begin
          pending_d = 1'b0;
          if (key_code == cur_key) begin
            hit_d     = 1'b1;
            perfect_d = cur_first;
          end else begin
            miss_d = 1'b1;
          end
        end
        if ((prev_beat_q == LAST) && (beat_cnt != LAST)) begin
          state_d = ST_DONE;
          if (pending_d) begin
            miss_d = 1'b1;
          end
          pending_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Judge state and registered judgement pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pending_q    <= 1'b0;
      first_beat_q <= 1'b0;
      exp_key_q    <= '0;
      prev_idx_q   <= '0;
      prev_beat_q  <= '0;
      hit_q        <= 1'b0;
      perfect_q    <= 1'b0;
      miss_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      first_beat_q <= first_beat_d;
      exp_key_q    <= exp_key_d;
      prev_idx_q   <= prev_idx_d;
      prev_beat_q  <= prev_beat_d;
      hit_q        <= hit_d;
      perfect_q    <= perfect_d;
      miss_q       <= miss_d;
    end
  end

  judge_score_acc #(
    .NOTE_W     (NOTE_W),
    .SCORE_W    (SCORE_W),
    .PERFECT_PTS(PERFECT_PTS),
    .GOOD_PTS   (GOOD_PTS)
  ) u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .hit      (hit_d),
    .perfect  (perfect_d),
    .miss     (miss_d),
    .score    (score),
    .combo    (combo),
    .max_combo(max_combo)
  );

  assign hit_pulse   = hit_q;
  assign hit_perfect = perfect_q;
  assign miss_pulse  = miss_q;
  assign playing     = (state_q == ST_PLAY);
  assign done        = (state_q == ST_DONE);

endmodule

// File: doc/note_judge.md
Name: note_judge

Overview:
- Downstream consumer of the beat-to-note lookup stage.
- Each cycle it receives the current note index (0 = no note) and the expected key for that note. It matches player key presses against the pending note and grades each note as perfect, good or miss.
- It maintains score, combo and max-combo counters.
- Its outputs feed the display/score stage and the game-over logic.

Parameters:
- BEAT_W, 7, width of beat_cnt
- NOTE_W, 6, width of note_idx, combo and max_combo
- KEY_W, 4, width of key codes
- SCORE_W, 14, width of score
- LAST_BEAT, 96, final beat of the song
- PERFECT_PTS, 3, points per perfect hit
- GOOD_PTS, 1, points per good hit

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins or restarts a game
- beat_cnt  in  BEAT_W  current beat from the beat counter
- note_idx  in  NOTE_W  note index for the current beat (0 = none)
- note_key  in  KEY_W  expected key for note_idx; stable while note_idx is stable
- key_valid  in  1  one-cycle press strobe
- key_code  in  KEY_W  pressed key, qualified by key_valid
- hit_pulse  out  1  registered one-cycle pulse, note hit
- hit_perfect  out  1  qualifies hit_pulse: 1 = perfect, 0 = good
- miss_pulse  out  1  registered one-cycle pulse, note missed
- score  out  SCORE_W  accumulated points, saturating
- combo  out  NOTE_W  consecutive hits, saturating
- max_combo  out  NOTE_W  highest combo this game
- playing  out  1  FSM is in PLAY
- done  out  1  FSM is in DONE

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. On reset: all outputs 0, FSM = IDLE, pending = 0, prev_idx = 0, prev_beat = 0.
- FSM states: IDLE, PLAY, DONE.
  - IDLE -> PLAY on start.
  - PLAY -> DONE when prev_beat == LAST_BEAT and beat_cnt != LAST_BEAT.
  - DONE -> PLAY on start.
  - start while in PLAY is ignored.
- Entry into PLAY:
  - Clears score, combo, max_combo and pending.
  - Sets prev_idx = note_idx and prev_beat = beat_cnt.
- New note detection (PLAY only): new_note = (note_idx != prev_idx) && (note_idx != 0). prev_idx and prev_beat are registered every cycle.
- On new_note:
  - If pending == 1, the previous note is graded miss.
  - pending <= 1.
  - first_beat <= 1.
  - exp_key <= note_key.
- first_beat clears when beat_cnt != prev_beat with no new_note in the same cycle.
- note_idx returning to 0 while pending: the note stays pending until the next new_note or end of song.
- Key press (PLAY only):
  - key_valid with pending == 1 and key_code == exp_key: hit, pending <= 0. Perfect if first_beat, else good.
  - key_valid with pending == 1 and a wrong key: miss, pending <= 0.
  - key_valid with pending == 0: ignored, no penalty.
- Simultaneous key_valid and new_note in one cycle:
  - The press is judged against the new note, using note_key and first_beat = 1.
  - The old pending note is graded miss.
  - miss_pulse and hit_pulse may both assert in that cycle.
- Latency: judgement pulses and counter updates appear one clock after the triggering input cycle.
- Counters:
  - Hit: combo +1, saturating at 2^NOTE_W-1. Score + PERFECT_PTS or GOOD_PTS, saturating at 2^SCORE_W-1.
  - Miss: combo <= 0. In the double-event cycle, miss applies before hit, so combo ends at 1.
  - max_combo <= max(max_combo, new combo) in the same cycle.
- End of song: on the PLAY -> DONE transition, a still-pending note is graded miss (miss_pulse asserts), then pending <= 0.
- IDLE/DONE: inputs are ignored and counters are held, so the score stays readable in DONE.

Optional Feature:
- Macro: NOTE_JUDGE_COMBO_BONUS_EN.
- Defined: a perfect hit whose pre-hit combo is >= 10 adds 2*PERFECT_PTS. Saturation rules are unchanged.
- Undefined: flat PERFECT_PTS. No extra logic is instantiated.

Decomposition:
- Shared package note_judge_pkg holds:
  - the FSM state encoding (IDLE, PLAY, DONE);
  - the point constants;
  - the combo bonus threshold (10);
  - LAST_BEAT.
- One sub-module, judge_score_acc: takes hit/perfect/miss/clear and produces score, combo and max_combo with saturation and the optional bonus. The FSM, note detection and grading stay in the top module.

Test Plan:
- Perfect hit: start, note_idx 0->1 with note_key=2, press key 2 in the same beat -> hit_pulse=1, hit_perfect=1, score=3, combo=1.
- Good hit, then miss on the next note:
  - Note 1 pressed correctly one beat late -> good, score=1.
  - Note advances to 2 unpressed, then to 3 -> miss_pulse on the 2->3 change, combo=0, max_combo=1.
- Wrong key: pending note expects 5, press 4 -> miss_pulse, pending cleared. A later press of 5 is ignored; score unchanged.
- Simultaneous events: note 3 pending; key matching note 4 arrives in the same cycle note_idx goes 3->4 -> miss_pulse and hit_pulse (perfect) in the same cycle, combo=1.
- End of song and reset:
  - Note pending when beat_cnt goes 96->0 -> miss_pulse, done=1. Score is held; start returns to PLAY with counters cleared.
  - rst_n low mid-PLAY -> all outputs 0 immediately.
- Saturation and bonus: force 20 perfect hits -> combo=20.
  - With NOTE_JUDGE_COMBO_BONUS_EN defined: score = 3*10 + 6*10 = 90.
  - Without the macro: score = 60.
